wb_gpio_irq: RTL and testbench
==============================

# wb_gpio_irq

Parametrised Wishbone GPIO port, 1-32 pins, with per-pin direction, atomic output toggle and a full interrupt controller. Each pin has its own enable, level/edge mode, polarity and sticky pending bit, and the pending bits are cleared by write-1-to-clear. It sits on the peripheral Wishbone bus as a slave and drives one active-high `irq` line to the CPU interrupt input.

## Interface
- `GPIO_WIDTH`, 8: number of pins, 1..32.
- `DIR_RESET`, 0: reset value of DIR (`GPIO_WIDTH` bits).
- `OUT_RESET`, 0: reset value of DATA_OUT (`GPIO_WIDTH` bits).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `wb_adr_i`  in  32  byte address; only `[4:2]` is decoded.
- `wb_dat_i`  in  32  write data.
- `wb_we_i`  in  1  write enable.
- `wb_cyc_i`  in  1  bus cycle.
- `wb_stb_i`  in  1  strobe.
- `wb_ack_o`  out  1  acknowledge.
- `wb_dat_o`  out  32  registered read data.
- `irq`  out  1  interrupt request, level, active-high.
- `gpio_io`  inout  `GPIO_WIDTH`  pads; pin *i* is driven with DATA_OUT[i] when DIR[i]=1, else high-Z.

## Operation
Register map, decoded on `adr[4:2]`. Bits at and above `GPIO_WIDTH` read 0 and ignore writes.
- 0 DATA_IN: read-only; returns the sampled pin value `pin_s` for all pins, regardless of direction.
- 1 DATA_OUT: read/write.
- 2 DIR: read/write; 1 = output.
- 3 IRQ_EN: read/write.
- 4 IRQ_TYPE: read/write; 0 = level, 1 = edge.
- 5 IRQ_POL: read/write; 1 = high level / rising edge, 0 = low level / falling edge.
- 6 IRQ_PEND: read; writing 1 clears the bit (W1C).
- 7 OUT_TGL: write XORs the data into DATA_OUT; reads 0.

Input path:
- `pin_s` is `gpio_io` registered once (twice with the sync option, see Configuration).
- `pin_d` is `pin_s` delayed by one cycle.

Event detection for pin *i* is qualified by `IRQ_EN[i] & ~DIR[i]`:
- Level mode: event whenever `pin_s[i] == IRQ_POL[i]`.
- Edge mode: event when `pin_s[i] != pin_d[i]` and `pin_s[i] == IRQ_POL[i]`.

Pending bits:
- An event sets `IRQ_PEND[i]`. The bit stays set until a W1C write to that bit.
- Same-cycle event and W1C on one bit: set wins.
- Level mode with the level still active: W1C clears the bit, and it sets again on the next event cycle.
- Clearing `IRQ_EN[i]` does not clear `IRQ_PEND[i]`; it only masks it from `irq`.

Interrupt output:
- `irq = |(IRQ_PEND & IRQ_EN)`, combinational from registers only, so it is glitch-free.

Reset values:
- DATA_OUT = `OUT_RESET`, DIR = `DIR_RESET`.
- IRQ_EN, IRQ_TYPE, IRQ_POL, IRQ_PEND = 0.
- `pin_s` and `pin_d` = 0; any edge seen right after reset is ignored because IRQ_EN = 0.
- `wb_ack_o` = 0, `wb_dat_o` = 0, `irq` = 0.
- Reset asserted mid-transaction drops `ack` on the next edge; the master must restart the transfer.

## Timing
- Wishbone classic. A request is `cyc & stb & ~ack_r`.
  - `ack_r` is set on the edge after the request and cleared on the following edge.
  - `wb_ack_o = ack_r & cyc & stb`.
  - Result: one access per 2 cycles, and exactly one ack per request.
- Write: the register updates on the same edge that raises `ack_r`.
- Read: `wb_dat_o` loads on the same edge that raises `ack_r` and holds until the next read.
- Pin to IRQ_PEND latency (no sync option):
  - pin changes before edge E0;
  - `pin_s` updates at E0;
  - IRQ_PEND updates at E1;
  - `irq` is high after E1.
- With the sync option, add 1 cycle.
- Write to DATA_OUT or DIR reaches the pads after the ack edge, with no extra delay.

## Configuration
- `WB_GPIO_IRQ_SYNC_EN` defined:
  - `pin_s` passes through a 2-flop synchroniser.
  - DATA_IN and event latency increase by 1 cycle.
- Not defined:
  - a single sampling flop only;
  - for synchronous-to-`clk` inputs only.

## Test plan
- Reset, then read addresses 0-7 with `GPIO_WIDTH`=8, `DIR_RESET`=0x0F, `OUT_RESET`=0xA5 -> DIR=0x0F; DATA_OUT=0xA5; all others 0 except DATA_IN = pads; `irq`=0; each ack one cycle wide.
- Write DIR=0xFF, DATA_OUT=0x3C, then OUT_TGL=0x0F -> pads show 0x3C then 0x33; DATA_OUT reads 0x33; bits [31:8] read 0.
- Pin 2 is an input; write IRQ_EN=0x04, IRQ_TYPE=0x04, IRQ_POL=0x04; drive pin 2 from 0 to 1 -> PEND=0x04 and `irq`=1 one cycle after `pin_s` rises (two with sync). Drive pin 2 from 1 to 0 -> no change. Write 0x04 to PEND -> `irq`=0.
- Pin 5 in level-low mode held low; write 0x20 to PEND -> bit reads 1 again on the next read and `irq` stays 1. Release pin 5 high and write W1C -> `irq`=0.
- Edge event on pin 0 in the same cycle as a W1C to bit 0 -> PEND[0]=1. Clear IRQ_EN[0] -> `irq`=0 with PEND[0] still 1.
- Pin 3 set as an output with its interrupt enabled; DATA_OUT[3] toggles -> PEND stays 0. Assert `rst` during an ack cycle -> ack=0 next cycle and all registers return to their reset values.

Source files
------------

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO port with per-pin direction, output toggle and interrupt controller.
// Define WB_GPIO_IRQ_SYNC_EN to add a 2-flop synchroniser on the pad inputs.
module wb_gpio_irq #(
    parameter int unsigned              GPIO_WIDTH = 8,
    parameter logic [GPIO_WIDTH-1:0]    DIR_RESET  = '0,
    parameter logic [GPIO_WIDTH-1:0]    OUT_RESET  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic                  wb_ack_o,
    output logic [31:0]           wb_dat_o,
    output logic                  irq,
    inout  wire  [GPIO_WIDTH-1:0] gpio_io
);

    typedef enum logic [2:0] {
        REG_DATA_IN  = 3'd0,
        REG_DATA_OUT = 3'd1,
        REG_DIR      = 3'd2,
        REG_IRQ_EN   = 3'd3,
        REG_IRQ_TYPE = 3'd4,
        REG_IRQ_POL  = 3'd5,
        REG_IRQ_PEND = 3'd6,
        REG_OUT_TGL  = 3'd7
    } reg_e;

    logic                  ack_r;
    logic [GPIO_WIDTH-1:0] out_r, dir_r, en_r, type_r, pol_r, pend_r;
    logic [GPIO_WIDTH-1:0] pin_s, pin_d;
    logic [GPIO_WIDTH-1:0] wdat, w1c, ev, ev_lvl, ev_edge;
    logic [31:0]           rdata;
    logic                  req, wr;
    reg_e                  reg_sel;
    logic                  unused;

    assign unused  = ^{wb_adr_i, wb_dat_i};
    assign reg_sel = reg_e'(wb_adr_i[4:2]);
    assign req     = wb_cyc_i & wb_stb_i & ~ack_r;
    assign wr      = req & wb_we_i;
    assign wdat    = wb_dat_i[GPIO_WIDTH-1:0];
    assign wb_ack_o = ack_r & wb_cyc_i & wb_stb_i;

    for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_pad
        assign gpio_io[g] = dir_r[g] ? out_r[g] : 1'bz;
    end

`ifdef WB_GPIO_IRQ_SYNC_EN
    logic [GPIO_WIDTH-1:0] pin_m;
    always_ff @(posedge clk) begin
        if (rst) begin
            pin_m <= '0;
            pin_s <= '0;
        end else begin
            pin_m <= gpio_io;
            pin_s <= pin_m;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) pin_s <= '0;
        else     pin_s <= gpio_io;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) pin_d <= '0;
        else     pin_d <= pin_s;
    end

    // Outputs never raise events: qualify with ~dir_r.
    always_comb begin
        ev_lvl  = ~(pin_s ^ pol_r);
        ev_edge = (pin_s ^ pin_d) & ev_lvl;
        ev      = en_r & ~dir_r & ((type_r & ev_edge) | (~type_r & ev_lvl));
        w1c     = (wr && reg_sel == REG_IRQ_PEND) ? wdat : '0;
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_DATA_IN:  rdata[GPIO_WIDTH-1:0] = pin_s;
            REG_DATA_OUT: rdata[GPIO_WIDTH-1:0] = out_r;
            REG_DIR:      rdata[GPIO_WIDTH-1:0] = dir_r;
            REG_IRQ_EN:   rdata[GPIO_WIDTH-1:0] = en_r;
            REG_IRQ_TYPE: rdata[GPIO_WIDTH-1:0] = type_r;
            REG_IRQ_POL:  rdata[GPIO_WIDTH-1:0] = pol_r;
            REG_IRQ_PEND: rdata[GPIO_WIDTH-1:0] = pend_r;
            REG_OUT_TGL:  rdata = '0;
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_r    <= 1'b0;
            wb_dat_o <= '0;
            out_r    <= OUT_RESET;
            dir_r    <= DIR_RESET;
            en_r     <= '0;
            type_r   <= '0;
            pol_r    <= '0;
            pend_r   <= '0;
        end else begin
            ack_r  <= req;
            // Set wins over a same-cycle W1C.
            pend_r <= (pend_r & ~w1c) | ev;
            if (req && !wb_we_i)
                wb_dat_o <= rdata;
            if (wr) begin
                case (reg_sel)
                    REG_DATA_OUT: out_r  <= wdat;
                    REG_DIR:      dir_r  <= wdat;
                    REG_IRQ_EN:   en_r   <= wdat;
                    REG_IRQ_TYPE: type_r <= wdat;
                    REG_IRQ_POL:  pol_r  <= wdat;
                    REG_OUT_TGL:  out_r  <= out_r ^ wdat;
                    default:      ;
                endcase
            end
        end
    end

    assign irq = |(pend_r & en_r);

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Scoreboard bench for wb_gpio_irq: reads push expectations, a monitor checks on ack.
module tb_wb_gpio_irq;

`ifdef WB_GPIO_IRQ_SYNC_EN
    localparam int SYNC = 1;
`else
    localparam int SYNC = 0;
`endif

    localparam logic [2:0] A_DIN = 3'd0, A_DOUT = 3'd1, A_DIR = 3'd2, A_EN = 3'd3,
                           A_TYPE = 3'd4, A_POL = 3'd5, A_PEND = 3'd6, A_TGL = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
    logic        wb_ack_o, irq;
    logic [31:0] wb_dat_o;
    wire  [7:0]  gpio_io;
    logic [7:0]  tb_en = 8'hF0;
    logic [7:0]  tb_drv = 8'h90;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 8; g++) begin : g_drv
        assign gpio_io[g] = tb_en[g] ? tb_drv[g] : 1'bz;
    end

    wb_gpio_irq #(.GPIO_WIDTH(8), .DIR_RESET(8'h0F), .OUT_RESET(8'hA5)) dut (
        .clk(clk), .rst(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o), .irq(irq), .gpio_io(gpio_io)
    );

    int checks = 0;
    int failures = 0;

    typedef struct { string name; logic [31:0] exp; } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [2:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        wb_adr_i = {27'h0, a, 2'b00};
        wb_dat_i = d;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_ack_o && n < 8);
        chk("ack_seen", {31'h0, wb_ack_o}, 32'h1);
        @(negedge clk);
        chk("ack_width", {31'h0, wb_ack_o}, 32'h0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        xfer(1'b1, a, d);
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
        sb.push_back('{name, exp});
        xfer(1'b0, a, '0);
    endtask

    task automatic read_reset_map();
        rd("rst_din",  A_DIN,  32'h95);
        rd("rst_dout", A_DOUT, 32'hA5);
        rd("rst_dir",  A_DIR,  32'h0F);
        rd("rst_en",   A_EN,   32'h0);
        rd("rst_type", A_TYPE, 32'h0);
        rd("rst_pol",  A_POL,  32'h0);
        rd("rst_pend", A_PEND, 32'h0);
        rd("rst_tgl",  A_TGL,  32'h0);
    endtask

    // Monitor: every read ack pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wb_ack_o && !wb_we_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read_ack: got data %h expected no ack", wb_dat_o);
                end else begin
                    e = sb.pop_front();
                    chk(e.name, wb_dat_o, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        read_reset_map();

        // Outputs, toggle, upper bits
        tb_en = 8'h00;
        wr(A_DIR, 32'hFF);
        wr(A_DOUT, 32'hFFFF_FF3C);
        chk("pads_3c", {24'h0, gpio_io}, 32'h3C);
        wr(A_TGL, 32'h0F);
        chk("pads_33", {24'h0, gpio_io}, 32'h33);
        rd("dout_33", A_DOUT, 32'h33);
        rd("tgl_reads0", A_TGL, 32'h0);

        // Pin 2 rising edge
        wr(A_DIR, 32'h00);
        tb_drv = 8'h00;
        tb_en  = 8'hFF;
        wr(A_POL, 32'h04);
        wr(A_TYPE, 32'h04);
        wr(A_EN, 32'h04);
        repeat (3) @(negedge clk);
        chk("edge_idle_irq", {31'h0, irq}, 32'h0);
        tb_drv[2] = 1'b1;
        @(negedge clk);
        repeat (SYNC) @(negedge clk);
        chk("edge_lat_irq0", {31'h0, irq}, 32'h0);
        @(negedge clk);
        chk("edge_lat_irq1", {31'h0, irq}, 32'h1);
        rd("edge_pend", A_PEND, 32'h04);
        tb_drv[2] = 1'b0;
        repeat (4) @(negedge clk);
        chk("fall_irq_held", {31'h0, irq}, 32'h1);
        rd("fall_pend", A_PEND, 32'h04);
        wr(A_PEND, 32'h04);
        chk("edge_w1c_irq", {31'h0, irq}, 32'h0);
        rd("edge_w1c_pend", A_PEND, 32'h0);

        // Pin 5 level low
        wr(A_EN, 32'h24);
        repeat (2) @(negedge clk);
        chk("lvl_irq", {31'h0, irq}, 32'h1);
        rd("lvl_pend", A_PEND, 32'h20);
        wr(A_PEND, 32'h20);
        rd("lvl_reset_pend", A_PEND, 32'h20);
        chk("lvl_irq_stays", {31'h0, irq}, 32'h1);
        tb_drv[5] = 1'b1;
        repeat (4) @(negedge clk);
        wr(A_PEND, 32'h20);
        chk("lvl_release_irq", {31'h0, irq}, 32'h0);
        rd("lvl_release_pend", A_PEND, 32'h0);

        // Pin 0 edge coincident with W1C
        wr(A_POL, 32'h05);
        wr(A_TYPE, 32'h05);
        wr(A_EN, 32'h25);
        @(negedge clk);
        tb_drv[0] = 1'b1;
        repeat (SYNC) @(negedge clk);
        wr(A_PEND, 32'h01);
        chk("race_irq", {31'h0, irq}, 32'h1);
        rd("race_pend", A_PEND, 32'h01);
        wr(A_EN, 32'h24);
        chk("mask_irq", {31'h0, irq}, 32'h0);
        rd("mask_pend", A_PEND, 32'h01);

        // Pin 3 as output must not raise events
        wr(A_PEND, 32'h01);
        tb_en = 8'hF7;
        wr(A_POL, 32'h0D);
        wr(A_TYPE, 32'h0D);
        wr(A_DIR, 32'h08);
        wr(A_EN, 32'h2C);
        wr(A_TGL, 32'h08);
        chk("pad3_high", {31'h0, gpio_io[3]}, 32'h1);
        wr(A_TGL, 32'h08);
        chk("pad3_low", {31'h0, gpio_io[3]}, 32'h0);
        repeat (3) @(negedge clk);
        rd("out_pin_pend", A_PEND, 32'h0);
        chk("out_pin_irq", {31'h0, irq}, 32'h0);

        // Reset during an ack
        tb_en  = 8'hF0;
        tb_drv = 8'h90;
        @(negedge clk);
        wb_adr_i = {27'h0, A_DOUT, 2'b00};
        wb_dat_i = 32'h0;
        wb_we_i  = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_ack_o && n < 8);
        chk("ack_before_rst", {31'h0, wb_ack_o}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("ack_after_rst", {31'h0, wb_ack_o}, 32'h0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst2_irq", {31'h0, irq}, 32'h0);
        read_reset_map();

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
